logic_arbiter: RTL

//  Shares one combinational logic unit (AND/OR/XOR) between NUM_REQ requesters.

---
 rtl/logic_arbiter_if.sv | 32 +++
 rtl/logic_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/logic_arbiter_if.sv
// Bundle of request/response signals between requesters and the shared logic unit.
// The arbiter uses the slave modport; requesters and the response consumer use the master modport.
interface logic_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_valid may rise/fall freely before grant; req_ready never depends on resp_ready.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_A;
    logic [NUM_REQ*DATA_W-1:0] req_B;
    logic [NUM_REQ*2-1:0]      req_op;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_res;
    logic [ID_W-1:0]           resp_id;
    logic                      busy;
    logic [1:0]                state_dbg;

    modport master (
        output req_valid, req_A, req_B, req_op, resp_ready,
        input  req_ready, resp_valid, resp_res, resp_id, busy, state_dbg
    );

    modport slave (
        input  req_valid, req_A, req_B, req_op, resp_ready,
        output req_ready, resp_valid, resp_res, resp_id, busy, state_dbg
    );
endinterface

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR unit between NUM_REQ requesters,
// with a registered issue stage and a single id-tagged response channel.
module logic_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input logic clk,
    input logic rst,
    logic_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] res_q;
    logic [ID_W-1:0]   rid_q;

    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] unit_res;
    logic              accept;
    logic              resp_take;

    // Round-robin search starting at ptr; wrap is explicit for non-power-of-two NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a  = bus.req_A[i*DATA_W +: DATA_W];
                sel_b  = bus.req_B[i*DATA_W +: DATA_W];
                sel_op = bus.req_op[i*2 +: 2];
            end
        end
    end

    always_comb begin
        unit_res = '0;
        case (op_q)
            2'b00:   unit_res = a_q & b_q;
            2'b01:   unit_res = a_q | b_q;
            2'b10:   unit_res = a_q ^ b_q;
            default: unit_res = '0;
        endcase
    end

    assign accept    = (state_q == IDLE) && grant_any && !rst;
    assign resp_take = (state_q == RESP) && bus.resp_ready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; req_ready is suppressed during reset even though state is IDLE.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_ready[i] = (grant_id == ID_W'(i));
            end
        end
        bus.resp_valid = (state_q == RESP);
        bus.busy       = (state_q != IDLE);
        bus.state_dbg  = state_q;
    end

    // Issue stage and response registers; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= '0;
            res_q <= '0;
            rid_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                op_q <= sel_op;
                id_q <= grant_id;
            end
            if (state_q == EXEC) begin
                res_q <= unit_res;
                rid_q <= id_q;
            end
            if (resp_take) begin
                if (rid_q == ID_W'(NUM_REQ - 1)) ptr_q <= '0;
                else                             ptr_q <= rid_q + ID_W'(1);
            end
        end
    end

    assign bus.resp_res = res_q;
    assign bus.resp_id  = rid_q;
endmodule
